counter_checker: RTL

COUNTER_CHECKER -- requirements
Module: counter_checker

---
 rtl/counter_checker.sv | 117 +++++++++++
 1 files changed

// File: rtl/counter_checker.sv
// counter_checker: on-line checker for a 4-bit up-counter with parallel load.
// A reference model tracks the counter under check and flags any cycle where
// the observed output differs from the prediction.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   enb         counter enable, as seen by the counter under check
//   modo        counter mode: 0 = count up, 1 = parallel load
//   data        counter parallel-load value
//   Q           observed counter output
//   expected    predicted Q for the current cycle
//   error       one-cycle pulse after a detected mismatch
//   err_sticky  set on the first mismatch, held until reset
//   err_count   saturating mismatch count
//   synced      high in CHECK or FAIL
//   fail        high in FAIL
module counter_checker #(
  parameter int unsigned ERR_W      = 8,
  parameter int unsigned FAIL_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             modo,
  input  logic [3:0]       data,
  input  logic [3:0]       Q,
  output logic [3:0]       expected,
  output logic             error,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count,
  output logic             synced,
  output logic             fail
);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_CHECK,
    ST_FAIL
  } state_t;

  localparam logic [ERR_W-1:0] LIMIT = ERR_W'(FAIL_LIMIT);
  localparam logic [ERR_W-1:0] ONE   = ERR_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       expected_q, expected_d;
  logic             error_q, error_d;
  logic             sticky_q, sticky_d;
  logic [ERR_W-1:0] count_q, count_d;
  logic             mismatch;
  logic [3:0]       base;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    error_d    = 1'b0;
    sticky_d   = sticky_q;
    count_d    = count_q;
    mismatch   = 1'b0;
    base       = expected_q;

    case (state_q)
      ST_SYNC: begin
        expected_d = Q;
        state_d    = ST_CHECK;
      end
      ST_CHECK, ST_FAIL: begin
        // Case inequality so that X/Z on Q is treated as a mismatch.
        mismatch = (Q !== expected_q);
        if (mismatch) begin
          // Resynchronise on the observed value so one fault counts once.
          base     = Q;
          error_d  = 1'b1;
          sticky_d = 1'b1;
          if (count_q != '1) begin
            count_d = count_q + ONE;
          end
        end
        if (enb) begin
          expected_d = modo ? data : base + 4'd1;
        end else begin
          expected_d = base;
        end
        if ((state_q == ST_CHECK) && (count_d >= LIMIT)) begin
          state_d = ST_FAIL;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SYNC;
      expected_q <= '0;
      error_q    <= 1'b0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      error_q    <= error_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  assign expected   = expected_q;
  assign error      = error_q;
  assign err_sticky = sticky_q;
  assign err_count  = count_q;
  assign synced     = (state_q == ST_CHECK) || (state_q == ST_FAIL);
  assign fail       = (state_q == ST_FAIL);

endmodule
